// File: rtl/commit_trace_tx_pkg.sv
// commit_trace_pkg: record type codes, record width and FSM state encoding shared by commit_trace_tx
package commit_trace_pkg;
  localparam int TRC_W = 36;
  localparam logic [3:0] TRC_REG = 4'd1;
  localparam logic [3:0] TRC_LOAD = 4'd2;
  localparam logic [3:0] TRC_STORE = 4'd3;
  localparam logic [3:0] TRC_SUM_BASE = 4'd8;
  typedef enum logic [1:0] {RUN, SUMMARY, DONE} trcState_t;
endpackage

// File: rtl/commit_trace_tx_if.sv
// commit_trace_tx_if: valid/ready record stream (master: valid, data out / ready in; slave: the reverse)
interface commit_trace_tx_if;
  import commit_trace_pkg::*;
  logic valid;
  logic ready;
  logic [TRC_W-1:0] data;
  modport master(output valid, data, input ready);
  modport slave(input valid, data, output ready);
endinterface

// File: rtl/commit_trace_tx_fifo.sv
// trace_fifo: 2-write/1-read first-word-fall-through FIFO; ports clk, rst (async active-low), wrEn0/wrData0 then wrEn1/wrData1, rdEn, rdData (0 when empty), empty, free
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 36
) (
  input  logic clk,
  input  logic rst,
  input  logic wrEn0,
  input  logic wrEn1,
  input  logic [W-1:0] wrData0,
  input  logic [W-1:0] wrData1,
  input  logic rdEn,
  output logic [W-1:0] rdData,
  output logic empty,
  output logic [$clog2(DEPTH):0] free
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp, wp1;
  logic [AW:0] cnt;
  logic rd;
  assign rd = rdEn & ~empty;
  assign wp1 = wp + AW'(wrEn0);
  always_ff @(posedge clk) begin
    if (wrEn0) mem[wp] <= wrData0;
    if (wrEn1) mem[wp1] <= wrData1;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wp + AW'(wrEn0) + AW'(wrEn1);
      rp <= rp + AW'(rd);
      cnt <= cnt + (AW+1)'(wrEn0) + (AW+1)'(wrEn1) - (AW+1)'(rd);
    end
  assign empty = cnt == '0;
  assign free = (AW+1)'(DEPTH) - cnt;
  // Gate the head so an empty FIFO presents all-zero data, matching reset.
  assign rdData = empty ? '0 : mem[rp];
endmodule

// File: rtl/commit_trace_tx.sv
// commit_trace_tx: packs commit events (REG/LOAD/STORE) into 36-bit records, streams them through a FIFO and appends counter summaries on halt
// Ports: clk; rst (async, active-low); reg_write/write_reg/write_data; mem_read/mem_write/mem_addr/mem_data_in/mem_data_out;
//        halt; icache_req/icache_hit/dcache_req/dcache_hit; trc (record stream master); overflow (sticky drop flag); done.
// Macro TRACE_CACHE_STATS_EN: builds the four cache counters and sends summary records k=2..5.
module commit_trace_tx
  import commit_trace_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic reg_write,
  input  logic [2:0] write_reg,
  input  logic [15:0] write_data,
  input  logic mem_read,
  input  logic mem_write,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_data_in,
  input  logic [15:0] mem_data_out,
  input  logic halt,
  input  logic icache_req,
  input  logic icache_hit,
  input  logic dcache_req,
  input  logic dcache_hit,
  commit_trace_tx_if.master trc,
  output logic overflow,
  output logic done
);
  localparam int FW = $clog2(FIFO_DEPTH);
`ifdef TRACE_CACHE_STATS_EN
  localparam int NCNT = 6;
  logic [NCNT-1:0] inc;
  assign inc = {icache_req, dcache_req, icache_hit, dcache_hit, halt | reg_write | mem_write, 1'b1};
`else
  localparam int NCNT = 2;
  logic [NCNT-1:0] inc;
  logic unusedCache;
  assign unusedCache = ^{icache_req, icache_hit, dcache_req, dcache_hit};
  assign inc = {halt | reg_write | mem_write, 1'b1};
`endif
  trcState_t state;
  logic [CNT_W-1:0] cnt [NCNT];
  logic [2:0] sumIdx;
  logic empty, pop, memEv, fits, sumPush, wr0, wr1;
  logic [FW:0] free;
  logic [FW+1:0] freeEff;
  logic [1:0] nRec;
  logic [31:0] sumVal;
  logic [TRC_W-1:0] regRec, memRec, sumRec, d0;
  assign trc.valid = ~empty;
  assign pop = trc.valid & trc.ready;
  assign memEv = mem_read | mem_write;
  assign nRec = 2'(reg_write) + 2'(memEv);
  // A record leaving this cycle frees its slot for this cycle's capture.
  assign freeEff = (FW+2)'(free) + (FW+2)'(pop);
  assign fits = freeEff >= (FW+2)'(nRec);
  assign regRec = {TRC_REG, 13'd0, write_reg, write_data};
  assign memRec = mem_write ? {TRC_STORE, mem_addr, mem_data_in} : {TRC_LOAD, mem_addr, mem_data_out};
  assign sumRec = {TRC_SUM_BASE + {1'b0, sumIdx}, sumVal};
  always_comb begin
    sumVal = '0;
    for (int i = 0; i < NCNT; i++) sumVal = sumIdx == 3'(i) ? 32'(cnt[i]) : sumVal;
  end
  assign sumPush = state == SUMMARY && freeEff != '0;
  // Whole-cycle drop: both writes share the same fits qualifier.
  assign wr0 = state == RUN ? fits & (reg_write | memEv) : sumPush;
  assign wr1 = state == RUN && fits && reg_write && memEv;
  assign d0 = state == RUN ? (reg_write ? regRec : memRec) : sumRec;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= RUN;
      sumIdx <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < NCNT; i++) cnt[i] <= '0;
    end else begin
      if (state == RUN) begin
        for (int i = 0; i < NCNT; i++) if (inc[i] && cnt[i] != '1) cnt[i] <= cnt[i] + CNT_W'(1);
        if (!fits) overflow <= 1'b1;
        if (halt) state <= SUMMARY;
      end
      if (sumPush) begin
        sumIdx <= sumIdx + 3'd1;
        if (sumIdx == 3'(NCNT-1)) state <= DONE;
      end
    end
  assign done = state == DONE && empty;
  trace_fifo #(.DEPTH(FIFO_DEPTH), .W(TRC_W)) fifo (
    .clk(clk),
    .rst(rst),
    .wrEn0(wr0),
    .wrEn1(wr1),
    .wrData0(d0),
    .wrData1(memRec),
    .rdEn(pop),
    .rdData(trc.data),
    .empty(empty),
    .free(free)
  );
endmodule

// File: tb/tb_commit_trace_tx.sv
// tb_commit_trace_tx: directed and randomized checks of commit_trace_tx against a queue-based reference model
module tb_commit_trace_tx;
  localparam int DEPTH = 16;
`ifdef TRACE_CACHE_STATS_EN
  localparam int NSUM = 6;
`else
  localparam int NSUM = 2;
`endif
  logic clk, rst;
  logic reg_write, mem_read, mem_write, halt;
  logic icache_req, icache_hit, dcache_req, dcache_hit;
  logic [2:0] write_reg;
  logic [15:0] write_data, mem_addr, mem_data_in, mem_data_out;
  logic overflow, done;
  int checks = 0, errors = 0;
  logic [35:0] q[$], pend[$], seen[$];
  logic [31:0] cntM [6];
  bit mOvf, halted;
  commit_trace_tx_if trc();
  commit_trace_tx #(.FIFO_DEPTH(DEPTH), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .halt(halt),
    .icache_req(icache_req), .icache_hit(icache_hit),
    .dcache_req(dcache_req), .dcache_hit(dcache_hit),
    .trc(trc), .overflow(overflow), .done(done)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(string tag, logic [35:0] got, logic [35:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [35:0] mk(logic [3:0] t, logic [15:0] a, logic [15:0] b);
    return {t, a, b};
  endfunction
  function automatic void bump(int i, logic c);
    if (c && cntM[i] != 32'hFFFF_FFFF) cntM[i]++;
  endfunction
  task automatic modelReset();
    q.delete();
    pend.delete();
    seen.delete();
    mOvf = 0;
    halted = 0;
    for (int i = 0; i < 6; i++) cntM[i] = 0;
  endtask
  task automatic modelStep();
    int free;
    logic [35:0] recs[$];
    free = DEPTH - q.size();
    if (trc.ready && q.size() > 0) begin
      void'(q.pop_front());
      free++;
    end
    if (!halted) begin
      if (reg_write) recs.push_back(mk(4'd1, 16'(write_reg), write_data));
      if (mem_write) recs.push_back(mk(4'd3, mem_addr, mem_data_in));
      else if (mem_read) recs.push_back(mk(4'd2, mem_addr, mem_data_out));
      if (recs.size() <= free) foreach (recs[i]) q.push_back(recs[i]);
      else mOvf = 1;
      bump(0, 1'b1);
      bump(1, halt | reg_write | mem_write);
      bump(2, dcache_hit);
      bump(3, icache_hit);
      bump(4, dcache_req);
      bump(5, icache_req);
      if (halt) begin
        halted = 1;
        for (int k = 0; k < NSUM; k++) pend.push_back(mk(4'(8 + k), cntM[k][31:16], cntM[k][15:0]));
      end
    end else if (pend.size() > 0 && free > 0) q.push_back(pend.pop_front());
  endtask
  task automatic checkOutputs();
    chk("valid", trc.valid, q.size() > 0);
    chk("data", trc.data, q.size() > 0 ? q[0] : 36'd0);
    chk("overflow", overflow, mOvf);
    chk("done", done, halted && pend.size() == 0 && q.size() == 0);
  endtask
  task automatic cycle();
    if (trc.valid && trc.ready) seen.push_back(trc.data);
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkOutputs();
  endtask
  task automatic idle();
    {reg_write, mem_read, mem_write, halt} = '0;
    {icache_req, icache_hit, dcache_req, dcache_hit} = '0;
    write_reg = '0;
    {write_data, mem_addr, mem_data_in, mem_data_out} = '0;
  endtask
  task automatic randIn(bit allowHalt);
    reg_write = 1'($urandom_range(0, 1));
    mem_read = $urandom_range(0, 2) == 0;
    mem_write = $urandom_range(0, 2) == 0;
    write_reg = 3'($urandom);
    write_data = 16'($urandom);
    mem_addr = 16'($urandom);
    mem_data_in = 16'($urandom);
    mem_data_out = 16'($urandom);
    icache_req = 1'($urandom);
    icache_hit = 1'($urandom);
    dcache_req = 1'($urandom);
    dcache_hit = 1'($urandom);
    halt = allowHalt && $urandom_range(0, 7) == 0;
  endtask
  task automatic doReset();
    rst = 0;
    modelReset();
    idle();
    repeat (2) @(negedge clk);
    rst = 1;
    checkOutputs();
  endtask
  task automatic drain(string tag);
    idle();
    trc.ready = 1;
    for (int i = 0; i < 200 && !done; i++) cycle();
    chk(tag, done, 1'b1);
  endtask
  initial begin
    int n;
    logic [35:0] r;
    rst = 0;
    trc.ready = 1;
    idle();
    modelReset();
    doReset();
    chk("rst_valid", trc.valid, 1'b0);
    chk("rst_data", trc.data, 36'd0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_done", done, 1'b0);
    reg_write = 1; write_reg = 3; write_data = 16'h1234;
    cycle();
    chk("reg_rec", trc.data, 36'h1_0003_1234);
    idle(); mem_write = 1; mem_addr = 16'h0040; mem_data_in = 16'hBEEF;
    cycle();
    chk("store_rec", trc.data, 36'h3_0040_BEEF);
    idle(); reg_write = 1; write_reg = 1; write_data = 16'h0005;
    mem_read = 1; mem_addr = 16'h0010; mem_data_out = 16'h00AA;
    cycle();
    chk("dual_first", trc.data, 36'h1_0001_0005);
    idle();
    cycle();
    chk("dual_second", trc.data, 36'h2_0010_00AA);
    cycle();
    chk("dual_empty", trc.valid, 1'b0);
    doReset();
    trc.ready = 0;
    for (int i = 0; i < 9; i++) begin
      reg_write = 1; write_reg = 3'(i); write_data = 16'hA000 + 16'(i);
      mem_read = 1; mem_addr = 16'h0100 + 16'(i); mem_data_out = 16'h0200 + 16'(i);
      cycle();
      if (i == 7) chk("bp_full_no_ovf", overflow, 1'b0);
    end
    chk("bp_ovf", overflow, 1'b1);
    chk("bp_head_stable", trc.data, 36'h1_0000_A000);
    idle();
    seen.delete();
    trc.ready = 1;
    repeat (16) cycle();
    chk("bp_count", 36'(seen.size()), 36'd16);
    chk("bp_last", seen.size() == 16 ? seen[15] : 36'd0, 36'h2_0107_0207);
    chk("bp_drained", trc.valid, 1'b0);
    doReset();
    for (int c = 1; c <= 10; c++) begin
      idle();
      if (c <= 4) begin reg_write = 1; write_reg = 3'(c); write_data = 16'(c); end
      if (c == 5) begin mem_write = 1; mem_addr = 16'h0020; mem_data_in = 16'h0077; end
      if (c == 10) halt = 1;
      cycle();
    end
    drain("halt_done");
    chk("halt_nrec", 36'(seen.size()), 36'(5 + NSUM));
    chk("sum_cycles", seen.size() > 5 ? seen[5] : 36'd0, 36'h8_0000_000A);
    chk("sum_insts", seen.size() > 6 ? seen[6] : 36'd0, 36'h9_0000_0006);
    doReset();
    for (int c = 0; c < 3; c++) begin
      idle(); icache_req = 1; icache_hit = 1;
      cycle();
    end
    idle(); halt = 1;
    cycle();
    drain("cache_done");
    n = 0;
    r = '0;
    foreach (seen[i]) begin
      if (seen[i][35:32] >= 4'd8) n++;
      if (seen[i][35:32] == 4'd11) r = seen[i];
    end
    chk("nsum", 36'(n), 36'(NSUM));
`ifdef TRACE_CACHE_STATS_EN
    chk("ichit_sum", r, 36'hB_0000_0003);
`else
    chk("no_ichit_sum", r, 36'd0);
`endif
    doReset();
    trc.ready = 0;
    for (int c = 0; c < 3; c++) begin
      idle(); reg_write = 1; write_reg = 3'(c); write_data = 16'h0300 + 16'(c);
      cycle();
    end
    idle(); halt = 1;
    cycle();
    idle();
    cycle();
    chk("mid_sum_valid", trc.valid, 1'b1);
    #1 rst = 0;
    #1 chk("async_rst_valid", trc.valid, 1'b0);
    modelReset();
    @(negedge clk);
    rst = 1;
    chk("post_rst_ovf", overflow, 1'b0);
    chk("post_rst_done", done, 1'b0);
    trc.ready = 1;
    reg_write = 1; write_reg = 2; write_data = 16'h0055;
    cycle();
    chk("post_rst_rec", trc.data, 36'h1_0002_0055);
    doReset();
    for (int i = 0; i < 300; i++) begin
      randIn(0);
      trc.ready = $urandom_range(0, 3) != 0;
      cycle();
    end
    idle(); halt = 1;
    cycle();
    for (int i = 0; i < 60; i++) begin
      randIn(1);
      trc.ready = $urandom_range(0, 1) != 0;
      cycle();
    end
    drain("rand_done");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
